mux_scanner: RTL and testbench



---
 rtl/mux_pkg.sv | 15 +
 rtl/scan_counter.sv | 54 +++++
 rtl/mux_scanner.sv | 103 ++++++++++
 tb/tb_mux_scanner.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode encodings and channel slicing helper for mux_scanner
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_XOR    = 2'b11
    } mode_e;

    function automatic int unsigned chan_base(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// rtl/scan_counter.sv - dwell counter and channel pointer for scan mode
module scan_counter #(
    parameter int NCH   = 4,
    parameter int DWELL = 4,
    parameter int CW    = 2,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] ptr,
    output logic          first,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST_P = CW'(NCH - 1);
    localparam logic [DW-1:0] LAST_D = DW'(DWELL - 1);

    logic [CW-1:0] ptr_q, ptr_nxt;
    logic [DW-1:0] dcnt_q, dcnt_cur, dcnt_nxt;
    logic          last;

    // ptr/first/wrap describe the cycle being sampled on this edge; a load
    // makes the entry edge count as the first dwell cycle of the new channel.
    always_comb begin
        ptr      = load ? load_val : ptr_q;
        dcnt_cur = load ? '0 : dcnt_q;
        first    = (dcnt_cur == '0);
        last     = (dcnt_cur == LAST_D);
        wrap     = first && (ptr == '0) && !load;
        ptr_nxt  = ptr;
        dcnt_nxt = dcnt_cur + DW'(1);
        if (last) begin
            dcnt_nxt = '0;
            ptr_nxt  = (ptr == LAST_P) ? '0 : ptr + CW'(1);
        end
    end

    // load without en (manual mode) only parks the dwell counter at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            dcnt_q <= '0;
        end else if (en) begin
            ptr_q  <= ptr_nxt;
            dcnt_q <= dcnt_nxt;
        end else if (load) begin
            dcnt_q <= '0;
        end
    end

endmodule

// File: rtl/mux_scanner.sv
// rtl/mux_scanner.sv - registered N:1 channel selector with manual, scan, hold and xor-reduce modes
module mux_scanner
    import mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    parameter  int DWELL = 4,
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [CW-1:0]        sel,
    input  logic [1:0]           mode,
    output logic [WIDTH-1:0]     y,
    output logic [CW-1:0]        ch,
    output logic                 y_valid,
    output logic                 wrap
);

    localparam int            DW    = $clog2(DWELL) + 1;
    localparam logic [CW:0]   NCH_W = (CW + 1)'(NCH);

    logic [WIDTH-1:0] chan [NCH];
    logic [WIDTH-1:0] red;
    logic [CW-1:0]    start, ptr;
    logic             sel_ok, scan_entry, load, en, first, wrap_c;
    mode_e            cur_mode, prev_mode;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        assign chan[k] = din[chan_base(k, WIDTH) +: WIDTH];
    end

    always_comb begin
        red = '0;
        for (int k = 0; k < NCH; k++) red = red ^ chan[k];
    end

    assign cur_mode   = mode_e'(mode);
    assign sel_ok     = ({1'b0, sel} < NCH_W);
    assign start      = sel_ok ? sel : '0;
    // coming back from hold resumes; coming from manual or xor restarts at sel
    assign scan_entry = (cur_mode == MODE_SCAN) &&
                        ((prev_mode == MODE_MANUAL) || (prev_mode == MODE_XOR));
    assign load       = scan_entry || (cur_mode == MODE_MANUAL);
    assign en         = (cur_mode == MODE_SCAN);

    scan_counter #(
        .NCH   (NCH),
        .DWELL (DWELL),
        .CW    (CW),
        .DW    (DW)
    ) u_scan_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (start),
        .en       (en),
        .ptr      (ptr),
        .first    (first),
        .wrap     (wrap_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            ch        <= '0;
            y_valid   <= 1'b0;
            wrap      <= 1'b0;
            prev_mode <= MODE_MANUAL;
        end else begin
            prev_mode <= cur_mode;
            wrap      <= 1'b0;
            case (cur_mode)
                MODE_MANUAL: begin
                    if (sel_ok) begin
                        y       <= chan[sel];
                        ch      <= sel;
                        y_valid <= 1'b1;
                    end else begin
                        y       <= '0;
                        y_valid <= 1'b0;
                    end
                end
                MODE_SCAN: begin
                    y       <= chan[ptr];
                    ch      <= ptr;
                    y_valid <= first;
                    wrap    <= wrap_c;
                end
                MODE_HOLD: begin
                    y_valid <= 1'b0;
                end
                default: begin
                    y       <= red;
                    ch      <= '0;
                    y_valid <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scanner.sv
// tb/tb_mux_scanner.sv - directed self-checking bench for mux_scanner
module tb_mux_scanner;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic [1:0]  sel;
    logic [1:0]  mode;

    logic [7:0] y_a, y_b, y_c;
    logic [1:0] ch_a, ch_b, ch_c;
    logic       v_a, v_b, v_c;
    logic       w_a, w_b, w_c;

    int errors = 0;
    int checks = 0;

    logic [7:0] tbl [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    mux_scanner #(.WIDTH(8), .NCH(4), .DWELL(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode),
        .y(y_a), .ch(ch_a), .y_valid(v_a), .wrap(w_a)
    );

    mux_scanner #(.WIDTH(8), .NCH(3), .DWELL(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din[23:0]), .sel(sel), .mode(mode),
        .y(y_b), .ch(ch_b), .y_valid(v_b), .wrap(w_b)
    );

    mux_scanner #(.WIDTH(8), .NCH(4), .DWELL(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode),
        .y(y_c), .ch(ch_c), .y_valid(v_c), .wrap(w_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din   = 32'h44332211;
        sel   = 2'd0;
        mode  = 2'b00;
        step();
        step();
        checks++; if (y_a !== 8'h00) begin errors++; $display("FAIL reset_y: got %h exp 00", y_a); end
        checks++; if (ch_a !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d exp 0", ch_a); end
        checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", v_a); end
        checks++; if (w_a !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b exp 0", w_a); end
        rst_n = 1'b1;
    endtask

    task automatic test_manual();
        mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
            checks++; if (y_a !== tbl[i]) begin errors++; $display("FAIL manual_y[%0d]: got %h exp %h", i, y_a, tbl[i]); end
            checks++; if (ch_a !== 2'(i)) begin errors++; $display("FAIL manual_ch[%0d]: got %0d exp %0d", i, ch_a, i); end
            checks++; if (v_a !== 1'b1) begin errors++; $display("FAIL manual_valid[%0d]: got %b exp 1", i, v_a); end
            checks++; if (w_a !== 1'b0) begin errors++; $display("FAIL manual_wrap[%0d]: got %b exp 0", i, w_a); end
        end
        checks++; if (y_b !== 8'h00) begin errors++; $display("FAIL manual_oor_y: got %h exp 00", y_b); end
        checks++; if (v_b !== 1'b0) begin errors++; $display("FAIL manual_oor_valid: got %b exp 0", v_b); end
        checks++; if (ch_b !== 2'd2) begin errors++; $display("FAIL manual_oor_ch_hold: got %0d exp 2", ch_b); end
    endtask

    task automatic test_scan();
        int ea, eb, ec;
        sel  = 2'd2;
        mode = 2'b01;
        for (int i = 0; i < 16; i++) begin
            step();
            ea = (2 + i / 4) % 4;
            eb = (2 + i / 4) % 3;
            ec = (2 + i) % 4;
            checks++; if (ch_a !== 2'(ea)) begin errors++; $display("FAIL scan_ch[%0d]: got %0d exp %0d", i, ch_a, ea); end
            checks++; if (y_a !== tbl[ea]) begin errors++; $display("FAIL scan_y[%0d]: got %h exp %h", i, y_a, tbl[ea]); end
            checks++; if (v_a !== (i % 4 == 0)) begin errors++; $display("FAIL scan_valid[%0d]: got %b exp %b", i, v_a, (i % 4 == 0)); end
            checks++; if (w_a !== (i == 8)) begin errors++; $display("FAIL scan_wrap[%0d]: got %b exp %b", i, w_a, (i == 8)); end
            checks++; if (ch_b !== 2'(eb)) begin errors++; $display("FAIL scan3_ch[%0d]: got %0d exp %0d", i, ch_b, eb); end
            checks++; if (w_b !== (i == 4)) begin errors++; $display("FAIL scan3_wrap[%0d]: got %b exp %b", i, w_b, (i == 4)); end
            checks++; if (ch_c !== 2'(ec)) begin errors++; $display("FAIL dwell1_ch[%0d]: got %0d exp %0d", i, ch_c, ec); end
            checks++; if (v_c !== 1'b1) begin errors++; $display("FAIL dwell1_valid[%0d]: got %b exp 1", i, v_c); end
            checks++; if (w_c !== (ec == 0)) begin errors++; $display("FAIL dwell1_wrap[%0d]: got %b exp %b", i, w_c, (ec == 0)); end
        end
    endtask

    task automatic test_hold_resume();
        mode = 2'b00;
        sel  = 2'd1;
        step();
        mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ch_a !== 2'd1) begin errors++; $display("FAIL pre_hold_ch[%0d]: got %0d exp 1", i, ch_a); end
        end
        mode = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (y_a !== 8'h22) begin errors++; $display("FAIL hold_y[%0d]: got %h exp 22", i, y_a); end
            checks++; if (ch_a !== 2'd1) begin errors++; $display("FAIL hold_ch[%0d]: got %0d exp 1", i, ch_a); end
            checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL hold_valid[%0d]: got %b exp 0", i, v_a); end
        end
        mode = 2'b01;
        step();
        checks++; if (ch_a !== 2'd1) begin errors++; $display("FAIL resume_ch0: got %0d exp 1", ch_a); end
        checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL resume_valid0: got %b exp 0", v_a); end
        step();
        checks++; if (ch_a !== 2'd2) begin errors++; $display("FAIL resume_ch1: got %0d exp 2", ch_a); end
        checks++; if (y_a !== 8'h33) begin errors++; $display("FAIL resume_y1: got %h exp 33", y_a); end
        checks++; if (v_a !== 1'b1) begin errors++; $display("FAIL resume_valid1: got %b exp 1", v_a); end
    endtask

    task automatic test_reduce();
        din  = 32'hF00FAA55;
        mode = 2'b11;
        step();
        checks++; if (y_a !== 8'h00) begin errors++; $display("FAIL xor_y0: got %h exp 00", y_a); end
        checks++; if (ch_a !== 2'd0) begin errors++; $display("FAIL xor_ch0: got %0d exp 0", ch_a); end
        checks++; if (v_a !== 1'b1) begin errors++; $display("FAIL xor_valid0: got %b exp 1", v_a); end
        checks++; if (w_a !== 1'b0) begin errors++; $display("FAIL xor_wrap0: got %b exp 0", w_a); end
        checks++; if (y_b !== 8'hF0) begin errors++; $display("FAIL xor3_y0: got %h exp f0", y_b); end
        din[7:0] = 8'h00;
        step();
        checks++; if (y_a !== 8'h55) begin errors++; $display("FAIL xor_y1: got %h exp 55", y_a); end
        checks++; if (y_b !== 8'hA5) begin errors++; $display("FAIL xor3_y1: got %h exp a5", y_b); end
        mode = 2'b10;
        step();
        checks++; if (y_a !== 8'h55) begin errors++; $display("FAIL xor_hold_y: got %h exp 55", y_a); end
        checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL xor_hold_valid: got %b exp 0", v_a); end
    endtask

    task automatic test_reset_mid_scan();
        din  = 32'h44332211;
        sel  = 2'd0;
        mode = 2'b01;
        for (int i = 0; i < 6; i++) step();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (y_a !== 8'h00) begin errors++; $display("FAIL midrst_y: got %h exp 00", y_a); end
        checks++; if (ch_a !== 2'd0) begin errors++; $display("FAIL midrst_ch: got %0d exp 0", ch_a); end
        checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b exp 0", v_a); end
        mode  = 2'b00;
        sel   = 2'd2;
        rst_n = 1'b1;
        step();
        checks++; if (y_a !== 8'h33) begin errors++; $display("FAIL postrst_y: got %h exp 33", y_a); end
        checks++; if (ch_a !== 2'd2) begin errors++; $display("FAIL postrst_ch: got %0d exp 2", ch_a); end
        checks++; if (v_a !== 1'b1) begin errors++; $display("FAIL postrst_valid: got %b exp 1", v_a); end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_scan();
        test_hold_resume();
        test_reduce();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
